// File: rtl/clock_enable_gen.sv
`default_nettype none
// ============================================================================
// Module      : clock_enable_gen
// Description : Multi-channel programmable clock-enable divider. Each channel
//               produces a one-cycle tick enable and a 50%-duty toggle output
//               from the single system clock; a channel may count the ticks
//               of the channel below it. Divisors reload through a
//               valid/ready port and take effect at the next wrap.
//               Optional macro CLKDIV_SYNC_EN adds a 'sync' input that
//               phase-aligns all enabled channels.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_enable_gen #(
    parameter int                      NUM_CH  = 2,
    parameter int                      CNT_W   = 16,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_RST = {16'd1019, 16'd51},
    parameter logic [NUM_CH-1:0]       CASCADE = 2'b10,
    localparam int                     CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] pend,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
`ifdef CLKDIV_SYNC_EN
    ,
    input  logic              sync
`endif
);

    // ------------------------------------------------------------------
    // Configuration port decode (shared by all channels)
    // ------------------------------------------------------------------
    logic [(1<<CH_W)-1:0] w_pend_pad;
    logic                 w_ch_ok;
    logic                 w_wr;
    logic                 cfg_err_q;
    logic                 cfg_err_d;

    // Pad pend to a power-of-two width so any cfg_ch value indexes safely.
    always_comb begin
        w_pend_pad               = '0;
        w_pend_pad[NUM_CH-1:0]   = pend;
    end

    assign w_ch_ok   = ({{(32-CH_W){1'b0}}, cfg_ch} < 32'(NUM_CH));
    // Out-of-range targets are always "ready" so the master never stalls.
    assign cfg_ready = w_ch_ok ? ~w_pend_pad[cfg_ch] : 1'b1;
    assign w_wr      = cfg_valid & cfg_ready & w_ch_ok;
    assign cfg_err_d = cfg_valid & ~w_ch_ok;
    assign cfg_err   = cfg_err_q;

    // Register the error flag so it is a clean one-cycle pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Divider channels
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam logic [CNT_W-1:0] C_DIV_RST = DIV_RST[gi*CNT_W +: CNT_W];

        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] shd_q, shd_d;
        logic             pend_q, pend_d;
        logic             tick_q, tick_d;
        logic             clk_q, clk_d;
        logic             w_ev;
        logic             w_wr_here;

        // Source event: free-running, or the registered tick of the channel below.
        if (gi == 0 || !CASCADE[gi]) begin : g_free
            assign w_ev = 1'b1;
        end else begin : g_casc
            assign w_ev = tick[gi-1];
        end

        assign w_wr_here = w_wr && (cfg_ch == CH_W'(gi));

        // Next-state: count, wrap, toggle and pick up a pending divisor at a wrap.
        always_comb begin
            cnt_d  = cnt_q;
            div_d  = div_q;
            shd_d  = shd_q;
            pend_d = pend_q;
            tick_d = 1'b0;
            clk_d  = clk_q;
            if (!ch_en[gi]) begin
                // Idle channel: parked at phase zero, divisor applies immediately.
                cnt_d = '0;
                clk_d = 1'b0;
                if (pend_q) begin
                    div_d  = shd_q;
                    pend_d = 1'b0;
                end
`ifdef CLKDIV_SYNC_EN
            end else if (sync) begin
                // Phase alignment: restart the period without issuing a tick.
                cnt_d = '0;
                clk_d = 1'b0;
                if (pend_q) begin
                    div_d  = shd_q;
                    pend_d = 1'b0;
                end
`endif
            end else if (w_ev) begin
                if (cnt_q == div_q) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    clk_d  = ~clk_q;
                    if (pend_q) begin
                        div_d  = shd_q;
                        pend_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // A write is only accepted while nothing is pending, so it never
            // collides with the apply above; a same-cycle wrap keeps the old div.
            if (w_wr_here) begin
                shd_d  = cfg_div;
                pend_d = 1'b1;
            end
        end

        // Channel state registers.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q  <= '0;
                div_q  <= C_DIV_RST;
                shd_q  <= C_DIV_RST;
                pend_q <= 1'b0;
                tick_q <= 1'b0;
                clk_q  <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                div_q  <= div_d;
                shd_q  <= shd_d;
                pend_q <= pend_d;
                tick_q <= tick_d;
                clk_q  <= clk_d;
            end
        end

        assign pend[gi]    = pend_q;
        assign tick[gi]    = tick_q;
        assign clk_out[gi] = clk_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_enable_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_enable_gen
// Description : Self-checking bench for clock_enable_gen. A third standalone
//               channel is added so that an out-of-range channel index exists.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_enable_gen;

    localparam int                      NUM_CH  = 3;
    localparam int                      CNT_W   = 16;
    localparam int                      CH_W    = 2;
    localparam logic [NUM_CH*CNT_W-1:0] DIV_RST = {16'd2, 16'd1019, 16'd51};
    localparam logic [NUM_CH-1:0]       CASCADE = 3'b010;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NUM_CH-1:0] ch_en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_err;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_out;
`ifdef CLKDIV_SYNC_EN
    logic              sync;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clk = ~clk;

    clock_enable_gen #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .DIV_RST (DIV_RST),
        .CASCADE (CASCADE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ch_en     (ch_en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_err   (cfg_err),
        .pend      (pend),
        .tick      (tick),
        .clk_out   (clk_out)
`ifdef CLKDIV_SYNC_EN
        ,
        .sync      (sync)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: each channel counts down the source events left
    // until its next tick, reloading D+1 at every period boundary.
    // ------------------------------------------------------------------
    int m_left [NUM_CH];
    int m_div  [NUM_CH];
    int m_sh   [NUM_CH];
    bit m_pend [NUM_CH];
    bit m_tick [NUM_CH];
    bit m_clk  [NUM_CH];
    bit m_err;

    function automatic void model_reset();
        logic [NUM_CH*CNT_W-1:0] rv;
        rv = DIV_RST;
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i]  = int'(rv[i*CNT_W +: CNT_W]);
            m_sh[i]   = m_div[i];
            m_left[i] = m_div[i] + 1;
            m_pend[i] = 1'b0;
            m_tick[i] = 1'b0;
            m_clk[i]  = 1'b0;
        end
        m_err = 1'b0;
    endfunction

    function automatic void model_apply(input int i);
        if (m_pend[i]) begin
            m_div[i]  = m_sh[i];
            m_pend[i] = 1'b0;
        end
        m_left[i] = m_div[i] + 1;
    endfunction

    function automatic void model_step();
        bit pt [NUM_CH];
        bit ev;
        bit wr;
        logic [NUM_CH-1:0] cas;
        cas = CASCADE;
        pt  = m_tick;
        for (int i = 0; i < NUM_CH; i++) begin
            ev = 1'b1;
            if (i > 0 && cas[i]) ev = pt[i-1];
            wr = cfg_valid && (int'(cfg_ch) == i) && !m_pend[i];
            m_tick[i] = 1'b0;
            if (!ch_en[i]) begin
                m_clk[i] = 1'b0;
                model_apply(i);
`ifdef CLKDIV_SYNC_EN
            end else if (sync) begin
                m_clk[i] = 1'b0;
                model_apply(i);
`endif
            end else if (ev) begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) begin
                    m_tick[i] = 1'b1;
                    m_clk[i]  = ~m_clk[i];
                    model_apply(i);
                end
            end
            if (wr) begin
                m_sh[i]   = int'(cfg_div);
                m_pend[i] = 1'b1;
            end
        end
        m_err = cfg_valid && (int'(cfg_ch) >= NUM_CH);
    endfunction

    // Advance the model on every edge and compare shortly after it.
    initial begin : compare
        logic [NUM_CH-1:0] et, ec, ep;
        logic              er;
        model_reset();
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (!reset_n) model_reset();
            else          model_step();
            #1;
            if (reset_n) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    et[i] = m_tick[i];
                    ec[i] = m_clk[i];
                    ep[i] = m_pend[i];
                end
                er = (int'(cfg_ch) < NUM_CH) ? !m_pend[int'(cfg_ch)] : 1'b1;
                chk("tick",      32'(tick),      32'(et));
                chk("clk_out",   32'(clk_out),   32'(ec));
                chk("pend",      32'(pend),      32'(ep));
                chk("cfg_err",   32'(cfg_err),   32'(m_err));
                chk("cfg_ready", 32'(cfg_ready), 32'(er));
            end
        end
    end

    task automatic wait_tick(input int ch, input int max, output int at);
        at = -1;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (tick[ch]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout_tick%0d: no tick in %0d cycles, expected one", ch, max);
        end
    endtask

    task automatic cfg_write(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] d);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = d;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Directed stimulus with hand-computed intervals.
    initial begin : stim
        int tr, ta, tb, tc, td, t;
        reset_n   = 1'b0;
        ch_en     = 3'b111;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
`ifdef CLKDIV_SYNC_EN
        sync      = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_tick",    32'(tick),    0);
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_pend",    32'(pend),    0);
        chk("rst_cfg_err", 32'(cfg_err), 0);

        // Default divisors: ch0 every 52, ch1 cascaded 52*1020 plus one stage lag.
        reset_n = 1'b1;
        tr = cyc;
        wait_tick(0, 200, ta);
        chk("ch0_first_tick", ta - tr, 52);
        chk("ch0_clk_out_hi", 32'(clk_out[0]), 1);
        wait_tick(0, 200, tb);
        chk("ch0_period", tb - ta, 52);
        chk("ch0_clk_out_lo", 32'(clk_out[0]), 0);
        wait_tick(1, 60000, tc);
        chk("ch1_first_tick", tc - tr, 53041);

        // Mid-period write of D=3 to ch0.
        wait_tick(0, 200, ta);
        repeat (10) @(negedge clk);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd3;
        #1 chk("ready_idle", 32'(cfg_ready), 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("pend0_set", 32'(pend[0]), 1);
        chk("ready_busy", 32'(cfg_ready), 0);
        wait_tick(0, 200, tb);
        chk("old_period", tb - ta, 52);
        chk("pend0_clr", 32'(pend[0]), 0);
        wait_tick(0, 200, tc);
        chk("new_period", tc - tb, 4);
        wait_tick(0, 200, td);
        chk("new_period2", td - tc, 4);

        // Back to D=51, then write D=3 exactly on a wrap edge.
        cfg_write(2'd0, 16'd51);
        wait_tick(0, 200, ta);
        chk("restore_wrap", ta - td, 4);
        wait_tick(0, 200, tb);
        chk("restored_period", tb - ta, 52);
        repeat (51) @(negedge clk);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd3;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("coinc_tick", 32'(tick[0]), 1);
        chk("coinc_pend", 32'(pend[0]), 1);
        tc = cyc;
        wait_tick(0, 200, td);
        chk("coinc_next_period", td - tc, 52);
        chk("coinc_pend_clr", 32'(pend[0]), 0);
        wait_tick(0, 200, ta);
        chk("coinc_after", ta - td, 4);
        cfg_write(2'd0, 16'd51);
        wait_tick(0, 200, tb);

        // Out-of-range channel index.
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd7;
        #1 chk("oor_ready", 32'(cfg_ready), 1);
        @(negedge clk);
        cfg_valid = 1'b0; cfg_ch = 2'd0;
        chk("oor_err", 32'(cfg_err), 1);
        chk("oor_pend", 32'(pend), 0);
        @(negedge clk);
        chk("oor_err_pulse", 32'(cfg_err), 0);

        // ch0 disabled for 10 cycles mid-count.
        wait_tick(0, 200, ta);
        repeat (20) @(negedge clk);
        ch_en = 3'b110;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("dis_tick0", 32'({tick[0], clk_out[0]}), 0);
        end
        ch_en = 3'b111;
        t = cyc;
        wait_tick(0, 200, tb);
        chk("reenable_first", tb - t, 52);

`ifdef CLKDIV_SYNC_EN
        // Phase alignment pulse mid-period.
        repeat (20) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        chk("sync_tick", 32'(tick), 0);
        chk("sync_clk_out", 32'(clk_out), 0);
        t = cyc;
        wait_tick(0, 200, tc);
        chk("sync_next_tick", tc - t, 52);
`endif

        // Asynchronous reset mid-period discards a pending divisor.
        cfg_write(2'd1, 16'd5);
        chk("pend1_set", 32'(pend[1]), 1);
        repeat (7) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_pend", 32'(pend), 0);
        chk("async_tick", 32'(tick), 0);
        chk("async_clk_out", 32'(clk_out), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        tr = cyc;
        wait_tick(0, 200, ta);
        chk("post_reset_tick", ta - tr, 52);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute bound on run time.
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
